// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_resolve_unit                                          |
// | Description : Evaluates a branch condition on two operands, issues a       |
// |               one-cycle PC redirect when taken, holds a flush of the       |
// |               younger pipeline stages and keeps saturating statistics.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module branch_resolve_unit #(
    parameter int DATA_W       = 8,
    parameter int PC_W         = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid_i,
    output logic              br_ready_o,
    input  logic [2:0]        br_op_i,
    input  logic              use_imm_i,
    input  logic [DATA_W-1:0] rs1_val_i,
    input  logic [DATA_W-1:0] rs2_val_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [PC_W-1:0]   target_i,
    output logic              redirect_valid_o,
    output logic [PC_W-1:0]   redirect_pc_o,
    output logic              flush_o,
    output logic              op_err_o,
    output logic [CNT_W-1:0]  taken_cnt_o,
    output logic [CNT_W-1:0]  resolved_cnt_o
);

    // Condition encodings
    localparam logic [2:0] c_OP_EQ     = 3'b000;
    localparam logic [2:0] c_OP_NE     = 3'b001;
    localparam logic [2:0] c_OP_LT     = 3'b010;
    localparam logic [2:0] c_OP_GE     = 3'b011;
    localparam logic [2:0] c_OP_LTU    = 3'b100;
    localparam logic [2:0] c_OP_GEU    = 3'b101;
    localparam logic [2:0] c_OP_ALWAYS = 3'b110;
    localparam logic [2:0] c_OP_RSVD   = 3'b111;

    // Flush counter is 4 bits wide: FLUSH_CYCLES never exceeds 15
    localparam int         c_FC_W      = 4;
    localparam logic [c_FC_W-1:0] c_FLUSH_RELOAD = c_FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t              state_q;
    logic                br_ready_q;
    logic                redirect_valid_q;
    logic [PC_W-1:0]     redirect_pc_q;
    logic                flush_q;
    logic                op_err_q;
    logic [c_FC_W-1:0]   flush_cnt_q;
    logic [CNT_W-1:0]    taken_cnt_q;
    logic [CNT_W-1:0]    taken_cnt_d;
    logic [CNT_W-1:0]    resolved_cnt_q;
    logic [CNT_W-1:0]    resolved_cnt_d;

    logic                w_accept;
    logic [DATA_W-1:0]   w_opb;
    logic                w_cond;
    logic                w_taken;
    logic                w_reserved;

    // br_ready is only high in IDLE, so accept implies the FSM is idle
    assign w_accept   = br_valid_i & br_ready_q;
    assign w_opb      = use_imm_i ? imm_i : rs2_val_i;
    assign w_reserved = (br_op_i == c_OP_RSVD);
    assign w_taken    = w_accept & w_cond;

    // Branch condition evaluation; reserved encoding resolves as not taken
    always_comb begin
        w_cond = 1'b0;
        case (br_op_i)
            c_OP_EQ:     w_cond = (rs1_val_i == w_opb);
            c_OP_NE:     w_cond = (rs1_val_i != w_opb);
            c_OP_LT:     w_cond = ($signed(rs1_val_i) <  $signed(w_opb));
            c_OP_GE:     w_cond = ($signed(rs1_val_i) >= $signed(w_opb));
            c_OP_LTU:    w_cond = (rs1_val_i <  w_opb);
            c_OP_GEU:    w_cond = (rs1_val_i >= w_opb);
            c_OP_ALWAYS: w_cond = 1'b1;
            default:     w_cond = 1'b0;
        endcase
    end

    // Saturating statistics next-state: stop at all-ones instead of wrapping
    always_comb begin
        resolved_cnt_d = resolved_cnt_q;
        taken_cnt_d    = taken_cnt_q;
        if (w_accept && !(&resolved_cnt_q)) begin
            resolved_cnt_d = resolved_cnt_q + CNT_W'(1);
        end
        if (w_taken && !(&taken_cnt_q)) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    // Control FSM with registered outputs, sticky error flag and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            br_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            flush_cnt_q      <= '0;
            op_err_q         <= 1'b0;
            taken_cnt_q      <= '0;
            resolved_cnt_q   <= '0;
        end else begin
            taken_cnt_q    <= taken_cnt_d;
            resolved_cnt_q <= resolved_cnt_d;
            if (w_accept && w_reserved) begin
                op_err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_taken) begin
                        redirect_pc_q    <= target_i;
                        redirect_valid_q <= 1'b1;
                        flush_q          <= 1'b1;
                        br_ready_q       <= 1'b0;
                        state_q          <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    redirect_valid_q <= 1'b0;
                    if (FLUSH_CYCLES == 1) begin
                        flush_q    <= 1'b0;
                        br_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        // REDIRECT already covered the first flush cycle
                        flush_cnt_q <= c_FLUSH_RELOAD;
                        state_q     <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == c_FC_W'(1)) begin
                        flush_q    <= 1'b0;
                        br_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - c_FC_W'(1);
                    end
                end
                default: begin
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                    br_ready_q       <= 1'b1;
                    state_q          <= ST_IDLE;
                end
            endcase
        end
    end

    assign br_ready_o       = br_ready_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_o          = flush_q;
    assign op_err_o         = op_err_q;
    assign taken_cnt_o      = taken_cnt_q;
    assign resolved_cnt_o   = resolved_cnt_q;

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution unit for the pipelined core. It compares two operands under a selectable condition (equal, not-equal, signed and unsigned ordering, unconditional) and registers a one-cycle PC redirect when the branch is taken. It then holds a flush of the younger pipeline stages for a configurable number of cycles and keeps saturating taken/resolved statistics. It sits between decode/execute operand delivery and the PC-select logic of the fetch stage.

## Interface
- DATA_W, 8, operand width (rs1_val, rs2_val, imm)
- PC_W, 8, program-counter / branch-target width
- FLUSH_CYCLES, 2, cycles flush stays high per taken branch; legal range 1..15
- CNT_W, 16, width of statistics counters
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- br_valid  in  1  branch request present this cycle
- br_ready  out  1  unit can accept a request (high only in IDLE)
- br_op  in  3  condition: 000 EQ, 001 NE, 010 LT signed, 011 GE signed, 100 LTU, 101 GEU, 110 ALWAYS, 111 reserved
- use_imm  in  1  1: operand B = imm; 0: operand B = rs2_val
- rs1_val  in  DATA_W  operand A
- rs2_val  in  DATA_W  register operand B
- imm  in  DATA_W  immediate operand B
- target  in  PC_W  branch destination
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  PC_W  registered target, valid with redirect_valid
- flush  out  1  squash younger stages
- op_err  out  1  sticky: reserved br_op was accepted; cleared only by reset
- taken_cnt  out  CNT_W  saturating count of taken branches
- resolved_cnt  out  CNT_W  saturating count of accepted requests

## Operation
- Accept = br_valid & br_ready. Inputs sampled only on accept; otherwise ignored (upstream holds request until br_ready).
- Operand B selected by use_imm; no sign extension, both are DATA_W.
- Condition evaluated combinationally on accept; signed ops compare two's complement DATA_W values.
- Reserved op 111: treated as not taken, sets op_err.
- FSM states IDLE, REDIRECT, FLUSH:
  - IDLE: br_ready=1. Accept with taken → redirect_pc<=target, go REDIRECT. Accept not taken → stay IDLE.
  - REDIRECT (1 cycle): redirect_valid=1, flush=1, br_ready=0. If FLUSH_CYCLES==1 → IDLE, else load flush counter with FLUSH_CYCLES-1 → FLUSH.
  - FLUSH: flush=1, br_ready=0; counter decrements each cycle; at count 1 → IDLE.
- Counters: resolved_cnt +1 on every accept; taken_cnt +1 on every taken accept; both saturate at all-ones (no wrap).
- redirect_pc holds its last value outside REDIRECT.

## Timing
- Reset (async assert, sync-safe deassert at clk edge): state IDLE, br_ready=1, redirect_valid=0, redirect_pc=0, flush=0, op_err=0, taken_cnt=0, resolved_cnt=0.
- Latency: accept at edge N → redirect_valid and flush high during cycle N+1; flush high for exactly FLUSH_CYCLES cycles (N+1 .. N+FLUSH_CYCLES); br_ready returns high in cycle N+FLUSH_CYCLES+1.
- Not-taken branch: zero bubbles; back-to-back not-taken accepts every cycle allowed.
- Counters update on the accepting edge (visible the cycle after).
- Reset asserted mid-REDIRECT/FLUSH: all outputs drop to reset values immediately; pending redirect is discarded.
- br_valid high while br_ready low: no accept, no counter change, no op_err update.

## Test plan
- Reset: drive rst_n=0 mid-FLUSH → flush, redirect_valid fall asynchronously; counters read 0, br_ready=1.
- EQ taken, FLUSH_CYCLES=2: rs1=0x05, imm=0x05, use_imm=1, target=0x38 → redirect_valid one cycle with redirect_pc=0x38, flush 2 cycles, br_ready low 2 cycles, taken_cnt=1, resolved_cnt=1.
- Signed vs unsigned: rs1=0x80, rs2=0x01 → LT taken, LTU not taken, GE not taken, GEU taken; four not-taken/taken outcomes match, resolved_cnt=4, taken_cnt=2.
- Back-to-back not-taken: NE with equal operands 0x10/0x10 for 5 consecutive cycles → br_ready stays 1, no redirect, resolved_cnt=5.
- Request during flush: issue ALWAYS (target=0x80), hold second request through flush → second accepted only in cycle N+FLUSH_CYCLES+1; exactly two redirects.
- Reserved op and saturation (CNT_W=4): br_op=111 → not taken, op_err=1 sticky; 20 ALWAYS accepts → taken_cnt stays 0xF.
